jt6295_adpcm_enc: RTL and testbench

Streaming OKI/Dialogic 4-bit ADPCM encoder, the encode-side counterpart of the JT6295 decode path. It accepts 12-bit signed PCM samples on a sample-rate strobe, typically the sample-rate enable from the JT6295 timing generator. It quantizes each sample against a predictor that tracks the decoder bit-exactly, and packs nibbles into bytes in ROM order. It is used to generate sample ROM images and for closed-loop decoder verification.

---
 rtl/jt6295_adpcm_enc.sv | 222 ++++++++++++++++++++++
 tb/tb_jt6295_adpcm_enc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt6295_adpcm_enc.sv
// jt6295_adpcm_enc -- streaming OKI/Dialogic 4-bit ADPCM encoder.
//
// Quantizes 12-bit signed PCM against a predictor that tracks the JT6295
// decoder bit-exactly. Nibbles are packed into bytes in ROM order: the first
// nibble goes in [7:4] and the second in [3:0].
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   cen         sample strobe; honoured only while idle
//   pcm[11:0]   signed PCM sample, latched on an accepted cen
//   busy        high while a sample is being encoded
//   data[7:0]   packed ADPCM byte
//   data_valid  byte available in data
//   data_ready  consumer accepts the byte when data_valid && data_ready
//   ovf         sticky overrun flag: dropped cen or dropped byte
//
// Configuration macro: JT6295_ENC_NIBBLE_EN. When defined, packing is
// bypassed and every nibble is emitted as {4'h0, code}.
module jt6295_adpcm_enc (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [11:0] pcm,
    output logic        busy,
    output logic [7:0]  data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        ovf
);

    typedef enum logic [2:0] {IDLE, SUB, B2, B1, B0, UPD} state_t;

    state_t             st;
    logic signed [11:0] pred;
    logic [11:0]        pcm_l;
    logic [5:0]         idx;
    logic               s, b2, b1, b0;
    logic [12:0]        mag;
    logic [12:0]        acc;
`ifndef JT6295_ENC_NIBBLE_EN
    logic               phase;
    logic [3:0]         hi;
`endif

    // OKI standard step table
    function automatic logic [10:0] step_lut(input logic [5:0] i);
        case (i)
            6'd0:  step_lut = 11'd16;   6'd1:  step_lut = 11'd17;
            6'd2:  step_lut = 11'd19;   6'd3:  step_lut = 11'd21;
            6'd4:  step_lut = 11'd23;   6'd5:  step_lut = 11'd25;
            6'd6:  step_lut = 11'd28;   6'd7:  step_lut = 11'd31;
            6'd8:  step_lut = 11'd34;   6'd9:  step_lut = 11'd37;
            6'd10: step_lut = 11'd41;   6'd11: step_lut = 11'd45;
            6'd12: step_lut = 11'd50;   6'd13: step_lut = 11'd55;
            6'd14: step_lut = 11'd60;   6'd15: step_lut = 11'd66;
            6'd16: step_lut = 11'd73;   6'd17: step_lut = 11'd80;
            6'd18: step_lut = 11'd88;   6'd19: step_lut = 11'd97;
            6'd20: step_lut = 11'd107;  6'd21: step_lut = 11'd118;
            6'd22: step_lut = 11'd130;  6'd23: step_lut = 11'd143;
            6'd24: step_lut = 11'd157;  6'd25: step_lut = 11'd173;
            6'd26: step_lut = 11'd190;  6'd27: step_lut = 11'd209;
            6'd28: step_lut = 11'd230;  6'd29: step_lut = 11'd253;
            6'd30: step_lut = 11'd279;  6'd31: step_lut = 11'd307;
            6'd32: step_lut = 11'd337;  6'd33: step_lut = 11'd371;
            6'd34: step_lut = 11'd408;  6'd35: step_lut = 11'd449;
            6'd36: step_lut = 11'd494;  6'd37: step_lut = 11'd544;
            6'd38: step_lut = 11'd598;  6'd39: step_lut = 11'd658;
            6'd40: step_lut = 11'd724;  6'd41: step_lut = 11'd796;
            6'd42: step_lut = 11'd876;  6'd43: step_lut = 11'd963;
            6'd44: step_lut = 11'd1060; 6'd45: step_lut = 11'd1166;
            6'd46: step_lut = 11'd1282; 6'd47: step_lut = 11'd1411;
            default: step_lut = 11'd1552;
        endcase
    endfunction

    // idx is held constant for the whole sample, so the lookup can stay
    // combinational and be reused by every compare stage.
    logic [10:0]        step;
    logic [12:0]        st0, st1, st2;       // step, step>>1, step>>2
    logic signed [12:0] diff;
    logic [12:0]        mag_abs;
    logic [3:0]         code;
    logic signed [13:0] pred_sum;
    logic signed [11:0] pred_nxt;
    logic signed [7:0]  adj;
    logic signed [7:0]  idx_sum;
    logic [5:0]         idx_nxt;

    always_comb begin
        step     = step_lut(idx);
        st0      = {2'b00, step};
        st1      = {3'b000, step[10:1]};
        st2      = {4'b0000, step[10:2]};
        diff     = $signed({pcm_l[11], pcm_l}) - $signed({pred[11], pred});
        mag_abs  = diff[12] ? 13'(-diff) : 13'(diff);
        code     = {s, b2, b1, b0};

        // Decoder reconstruction: pred +/- acc, saturated to 12 bits
        pred_sum = s ? ($signed({{2{pred[11]}}, pred}) - $signed({1'b0, acc}))
                     : ($signed({{2{pred[11]}}, pred}) + $signed({1'b0, acc}));
        if (pred_sum > 14'sd2047)
            pred_nxt = 12'sd2047;
        else if (pred_sum < -14'sd2048)
            pred_nxt = -12'sd2048;
        else
            pred_nxt = pred_sum[11:0];

        // magnitude 4..7 -> +2,+4,+6,+8 ; 0..3 -> -1
        adj      = b2 ? ($signed({5'b00000, b1, b0, 1'b0}) + 8'sd2) : -8'sd1;
        idx_sum  = $signed({2'b00, idx}) + adj;
        if (idx_sum < 8'sd0)
            idx_nxt = 6'd0;
        else if (idx_sum > 8'sd48)
            idx_nxt = 6'd48;
        else
            idx_nxt = idx_sum[5:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            pred       <= '0;
            pcm_l      <= '0;
            idx        <= '0;
            s          <= 1'b0;
            b2         <= 1'b0;
            b1         <= 1'b0;
            b0         <= 1'b0;
            mag        <= '0;
            acc        <= '0;
            busy       <= 1'b0;
            data       <= 8'h00;
            data_valid <= 1'b0;
            ovf        <= 1'b0;
`ifndef JT6295_ENC_NIBBLE_EN
            phase      <= 1'b0;
            hi         <= 4'h0;
`endif
        end else begin
            // Handshake clears valid; a load in UPD below overrides it.
            if (data_valid && data_ready)
                data_valid <= 1'b0;

            if (cen && st != IDLE)
                ovf <= 1'b1;

            case (st)
                IDLE: if (cen) begin
                    pcm_l <= pcm;
                    busy  <= 1'b1;
                    st    <= SUB;
                end
                SUB: begin
                    s   <= diff[12];
                    mag <= mag_abs;
                    acc <= {5'b00000, step[10:3]};
                    b2  <= 1'b0;
                    b1  <= 1'b0;
                    b0  <= 1'b0;
                    st  <= B2;
                end
                B2: begin
                    if (mag >= st0) begin
                        b2  <= 1'b1;
                        mag <= mag - st0;
                        acc <= acc + st0;
                    end
                    st <= B1;
                end
                B1: begin
                    if (mag >= st1) begin
                        b1  <= 1'b1;
                        mag <= mag - st1;
                        acc <= acc + st1;
                    end
                    st <= B0;
                end
                B0: begin
                    if (mag >= st2) begin
                        b0  <= 1'b1;
                        acc <= acc + st2;
                    end
                    st <= UPD;
                end
                UPD: begin
                    pred <= pred_nxt;
                    idx  <= idx_nxt;
`ifdef JT6295_ENC_NIBBLE_EN
                    if (data_valid && !data_ready)
                        ovf <= 1'b1;
                    else begin
                        data       <= {4'h0, code};
                        data_valid <= 1'b1;
                    end
`else
                    if (!phase) begin
                        hi    <= code;
                        phase <= 1'b1;
                    end else begin
                        // A byte still pending means the consumer fell behind.
                        if (data_valid && !data_ready)
                            ovf <= 1'b1;
                        else begin
                            data       <= {hi, code};
                            data_valid <= 1'b1;
                        end
                        phase <= 1'b0;
                    end
`endif
                    busy <= 1'b0;
                    st   <= IDLE;
                end
                default: begin
                    busy <= 1'b0;
                    st   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt6295_adpcm_enc.sv
// Self-checking bench for jt6295_adpcm_enc: a sample-level behavioural model
// is compared with the DUT on every cycle, plus an independent OKI decoder
// that replays the emitted bytes and must follow the model's predictor.
module tb_jt6295_adpcm_enc;

    logic        clk = 1'b0;
    logic        rst, cen, data_ready;
    logic [11:0] pcm;
    logic        busy, data_valid, ovf;
    logic [7:0]  data;

    jt6295_adpcm_enc dut (
        .clk(clk), .rst(rst), .cen(cen), .pcm(pcm), .busy(busy),
        .data(data), .data_valid(data_valid), .data_ready(data_ready), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int tbl[49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55,
                    60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190,
                    209, 230, 253, 279, 307, 337, 371, 408, 449, 494, 544, 598,
                    658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552};
    int adj_t[8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

    // ---------------- behavioural model (one whole sample at a time) -------
    int       m_pred, m_idx, m_cnt, m_pcm, m_phase, m_hi;
    logic [7:0] m_data;
    bit       m_dv, m_ovf;
    int       q[$];          // model pred after each nibble

    task automatic encode(input bit old_dv);
        int diff, mag, step, acc, code, p, ni;
        bit sgn;
        diff = m_pcm - m_pred;
        sgn  = diff < 0;
        mag  = sgn ? -diff : diff;
        step = tbl[m_idx];
        acc  = step / 8;
        code = 0;
        if (mag >= step)     begin code += 4; mag -= step;     acc += step;     end
        if (mag >= step / 2) begin code += 2; mag -= step / 2; acc += step / 2; end
        if (mag >= step / 4) begin code += 1;                  acc += step / 4; end
        p = sgn ? m_pred - acc : m_pred + acc;
        m_pred = (p > 2047) ? 2047 : (p < -2048) ? -2048 : p;
        ni = m_idx + adj_t[code];
        m_idx = (ni < 0) ? 0 : (ni > 48) ? 48 : ni;
        q.push_back(m_pred);
        if (sgn) code += 8;
`ifdef JT6295_ENC_NIBBLE_EN
        if (old_dv && !data_ready) m_ovf = 1;
        else begin m_data = 8'(code); m_dv = 1; end
`else
        if (m_phase == 0) begin
            m_hi = code;
            m_phase = 1;
        end else begin
            if (old_dv && !data_ready) m_ovf = 1;
            else begin m_data = 8'((m_hi << 4) | code); m_dv = 1; end
            m_phase = 0;
        end
`endif
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pred = 0; m_idx = 0; m_cnt = 0; m_pcm = 0; m_phase = 0; m_hi = 0;
            m_data = 8'h00; m_dv = 0; m_ovf = 0;
        end else begin
            bit old_dv;
            old_dv = m_dv;
            if (m_dv && data_ready) m_dv = 0;
            if (m_cnt == 0) begin
                if (cen) begin m_pcm = int'($signed(pcm)); m_cnt = 5; end
            end else begin
                if (cen) m_ovf = 1;
                m_cnt--;
                if (m_cnt == 0) encode(old_dv);
            end
        end
    end

    // ---------------- independent decoder ---------------------------------
    int d_pred, d_idx;
    bit chk_en = 0, chk_dec = 0;

    task automatic dec(input int n);
        int step, d, ni;
        step = tbl[d_idx];
        d = step >> 3;
        if (n[2]) d += step;
        if (n[1]) d += step >> 1;
        if (n[0]) d += step >> 2;
        d_pred = n[3] ? d_pred - d : d_pred + d;
        if (d_pred > 2047) d_pred = 2047;
        if (d_pred < -2048) d_pred = -2048;
        ni = d_idx + adj_t[n & 7];
        d_idx = (ni < 0) ? 0 : (ni > 48) ? 48 : ni;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic dec_chk(input int n);
        int e;
        dec(n);
        if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL dec_queue actual=empty expected=pred");
        end else begin
            e = q.pop_front();
            chk("dec_pred", d_pred, e);
        end
    endtask

    // ---------------- per-cycle compare ------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (busy !== (m_cnt != 0) || data_valid !== m_dv || ovf !== m_ovf ||
                data !== m_data) begin
                failures++;
                $display("FAIL cycle busy=%b/%b dv=%b/%b ovf=%b/%b data=%h/%h (actual/expected) t=%0t",
                         busy, m_cnt != 0, data_valid, m_dv, ovf, m_ovf, data, m_data, $time);
            end
            if (chk_dec && data_valid && data_ready) begin
`ifndef JT6295_ENC_NIBBLE_EN
                dec_chk(int'(data[7:4]));
`endif
                dec_chk(int'(data[3:0]));
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1; cen = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    // Pulse cen and return six cycles later, at the minimum legal spacing.
    task automatic send(input logic [11:0] v);
        cen = 1; pcm = v;
        @(negedge clk);
        cen = 0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst = 1; cen = 0; pcm = '0; data_ready = 1;
        do_reset();
        chk_en = 1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_dv", int'(data_valid), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_ovf", int'(ovf), 0);

        // silence: second nibble sees diff = -2, so sign bit is set
        send(12'd0);
        chk("zero1_pred", m_pred, 2);
        chk("zero1_idx", m_idx, 0);
        chk("zero1_dv", int'(data_valid), 0);
        send(12'd0);
        chk("zero2_pred", m_pred, 0);
`ifndef JT6295_ENC_NIBBLE_EN
        chk("zero2_data", int'(data), 8'h08);
        chk("zero2_dv", int'(data_valid), 1);
`endif

        // positive full scale
        do_reset();
        send(12'd2047);
        chk("pos1_pred", m_pred, 30);
        chk("pos1_idx", m_idx, 8);
        send(12'd2047);
        chk("pos2_pred", m_pred, 93);
        chk("pos2_idx", m_idx, 16);
`ifndef JT6295_ENC_NIBBLE_EN
        chk("pos2_data", int'(data), 8'h77);
`endif

        // negative full scale
        do_reset();
        send(12'h800);
        chk("neg1_pred", m_pred, -30);
        chk("neg1_idx", m_idx, 8);
        send(12'h800);
`ifndef JT6295_ENC_NIBBLE_EN
        chk("neg2_data", int'(data), 8'hFF);
`endif

        // cen during busy is dropped and flags overrun
        do_reset();
        cen = 1; pcm = 12'd2047;
        @(negedge clk); cen = 0;
        repeat (2) @(negedge clk);
        cen = 1; pcm = 12'h800;
        @(negedge clk); cen = 0;
        repeat (6) @(negedge clk);
        chk("ovf_cen", int'(ovf), 1);
        chk("ovf_pred", m_pred, 30);
        chk("ovf_idx", m_idx, 8);

        // back-pressure: second byte dropped, first held
        do_reset();
        data_ready = 0;
        repeat (4) send(12'd2047);
        repeat (2) @(negedge clk);
`ifndef JT6295_ENC_NIBBLE_EN
        chk("bp_data", int'(data), 8'h77);
`endif
        chk("bp_dv", int'(data_valid), 1);
        chk("bp_ovf", int'(ovf), 1);
        data_ready = 1;
        @(negedge clk);
        chk("bp_hs_dv", int'(data_valid), 0);

        // closed loop against the decoder
        do_reset();
        q.delete();
        d_pred = 0; d_idx = 0;
        chk_dec = 1;
        for (int i = 0; i < 10000; i++)
            send(12'($urandom));
        repeat (3) @(negedge clk);
        chk_dec = 0;
        chk("dec_leftover", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
